// File: rtl/muldiv_unit.sv
// ============================================================================
// muldiv_unit : iterative 32-bit shift-add multiply / restoring divide
// Revision    : 1.0
// ============================================================================
`default_nettype none

module muldiv_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result_hi,
  output logic [31:0] result_lo,
  output logic        div_by_zero
);

  localparam logic [4:0] C_LAST_ITER = 5'd31;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CALC   = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        sign_a_q, sign_a_d;
  logic        sign_b_q, sign_b_d;
  logic [63:0] acc_q, acc_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        dbz_q, dbz_d;

  logic        w_in_sign_a, w_in_sign_b;
  logic [31:0] w_in_mag_a, w_in_mag_b;
  logic [32:0] w_mul_sum;
  logic [63:0] w_mul_next;
  logic [32:0] w_rem_shift;
  logic [32:0] w_rem_sub;
  logic        w_div_fits;
  logic [63:0] w_div_next;
  logic [63:0] w_prod_neg;
  logic        w_sign_x;

  // Signed ops work on magnitudes; unsigned ops never see a sign bit.
  assign w_in_sign_a = op[0] & op_a[31];
  assign w_in_sign_b = op[0] & op_b[31];
  assign w_in_mag_a  = w_in_sign_a ? (~op_a + 32'd1) : op_a;
  assign w_in_mag_b  = w_in_sign_b ? (~op_b + 32'd1) : op_b;

  // Multiply: acc = {partial product, remaining multiplier bits}, shifted right.
  assign w_mul_sum  = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? a_q : 32'd0)};
  assign w_mul_next = {w_mul_sum, acc_q[31:1]};

  // Divide: acc = {partial remainder, dividend/quotient}, shifted left.
  assign w_rem_shift = {acc_q[63:32], acc_q[31]};
  assign w_rem_sub   = w_rem_shift - {1'b0, b_q};
  assign w_div_fits  = (w_rem_shift >= {1'b0, b_q});
  assign w_div_next  = w_div_fits ? {w_rem_sub[31:0], acc_q[30:0], 1'b1}
                                  : {w_rem_shift[31:0], acc_q[30:0], 1'b0};

  assign w_prod_neg = ~acc_q + 64'd1;
  assign w_sign_x   = sign_a_q ^ sign_b_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      count_q  <= 5'd0;
      op_q     <= 2'd0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      acc_q    <= 64'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      acc_q    <= acc_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dbz_q    <= dbz_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    acc_d    = acc_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dbz_d    = dbz_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d     = op;
          a_d      = w_in_mag_a;
          b_d      = w_in_mag_b;
          sign_a_d = w_in_sign_a;
          sign_b_d = w_in_sign_b;
          count_d  = 5'd0;
          busy_d   = 1'b1;
          acc_d    = op[1] ? {32'd0, w_in_mag_a} : {32'd0, w_in_mag_b};
          state_d  = S_CALC;
        end
      end

      S_CALC: begin
        acc_d   = op_q[1] ? w_div_next : w_mul_next;
        count_d = count_q + 5'd1;
        if (count_q == C_LAST_ITER) begin
          state_d = S_FINISH;
        end
      end

      S_FINISH: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        if (!op_q[1]) begin
          {hi_d, lo_d} = w_sign_x ? w_prod_neg : acc_q;
          dbz_d        = 1'b0;
        end else if (b_q == 32'd0) begin
          // Recover op_a as presented: negating the magnitude restores it.
          lo_d  = 32'hFFFF_FFFF;
          hi_d  = sign_a_q ? (~a_q + 32'd1) : a_q;
          dbz_d = 1'b1;
        end else begin
          lo_d  = w_sign_x ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
          hi_d  = sign_a_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
          dbz_d = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign result_hi   = hi_q;
  assign result_lo   = lo_q;
  assign div_by_zero = dbz_q;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ============================================================================
// tb_muldiv_unit : randomized + directed bench for muldiv_unit vs. arithmetic model
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] op_a = 32'd0;
  logic [31:0] op_b = 32'd0;
  logic        busy, done, div_by_zero;
  logic [31:0] result_hi, result_lo;

  int checks = 0;
  int failures = 0;
  logic mon_en = 1'b0;

  muldiv_unit dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .op_a        (op_a),
    .op_b        (op_b),
    .busy        (busy),
    .done        (done),
    .result_hi   (result_hi),
    .result_lo   (result_lo),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // {div_by_zero, result_hi, result_lo} straight from the arithmetic definition.
  function automatic logic [64:0] ref_op(input logic [1:0] o, input logic [31:0] a,
                                         input logic [31:0] b);
    logic signed [63:0] sa, sb, p, q, r;
    logic [63:0] up;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ref_op = 65'd0;
    case (o)
      2'd0: begin up = {32'd0, a} * {32'd0, b}; ref_op = {1'b0, up}; end
      2'd1: begin p = sa * sb; ref_op = {1'b0, p}; end
      default: begin
        if (b == 32'd0) ref_op = {1'b1, a, 32'hFFFF_FFFF};
        else if (o == 2'd2) ref_op = {1'b0, a % b, a / b};
        else begin
          q = sa / sb;
          r = sa % sb;
          ref_op = {1'b0, r[31:0], q[31:0]};
        end
      end
    endcase
  endfunction

  // Timeline model: an accepted start yields done 33 edges later.
  logic        m_busy = 1'b0, m_done = 1'b0, m_dbz = 1'b0;
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0;
  logic [64:0] m_pend = 65'd0;
  int          m_rem = 0;

  always @(posedge clk) begin
    if (!reset) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_dbz <= 1'b0;
      m_hi <= 32'd0; m_lo <= 32'd0; m_rem <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_rem > 0) begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) begin
          m_done <= 1'b1;
          m_busy <= 1'b0;
          {m_dbz, m_hi, m_lo} <= m_pend;
        end
      end else if (start) begin
        m_rem  <= 33;
        m_busy <= 1'b1;
        m_pend <= ref_op(op, op_a, op_b);
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      chk("cmp_busy", 65'(busy), 65'(m_busy));
      chk("cmp_done", 65'(done), 65'(m_done));
      chk("cmp_result", {div_by_zero, result_hi, result_lo}, {m_dbz, m_hi, m_lo});
    end
  end

  function automatic logic [31:0] pick();
    case ($urandom % 8)
      0: pick = 32'd0;
      1: pick = 32'hFFFF_FFFF;
      2: pick = 32'h8000_0000;
      3: pick = 32'd1;
      4: pick = 32'($urandom % 16);
      default: pick = $urandom;
    endcase
  endfunction

  // Called on a negedge while idle; returns on the negedge after the accepting edge.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; op_a = a; op_b = b;
    @(negedge clk);
    start = 1'b0; op = 2'($urandom); op_a = $urandom; op_b = $urandom;
  endtask

  task automatic wait_done(output int lat, output int bcyc);
    lat = 0;
    bcyc = busy ? 1 : 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      if (busy) bcyc++;
    end
  endtask

  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [64:0] exp);
    int lat, bcyc;
    issue(o, a, b);
    wait_done(lat, bcyc);
    chk({name, "_latency"}, 65'(lat), 65'd33);
    chk({name, "_busy_cycles"}, 65'(bcyc), 65'd33);
    chk({name, "_result"}, {div_by_zero, result_hi, result_lo}, exp);
  endtask

  initial begin
    int lat, bcyc, ndone;

    chk("model_mulu", ref_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF), {1'b0, 32'hFFFF_FFFE, 32'h0000_0001});
    chk("model_mul",  ref_op(2'd1, 32'hFFFF_FFFD, 32'd7),         {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB});
    chk("model_div",  ref_op(2'd3, 32'hFFFF_FFF9, 32'd2),         {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
    chk("model_ovf",  ref_op(2'd3, 32'h8000_0000, 32'hFFFF_FFFF), {1'b0, 32'h0000_0000, 32'h8000_0000});
    chk("model_dbz",  ref_op(2'd2, 32'd100, 32'd0),               {1'b1, 32'd100, 32'hFFFF_FFFF});

    @(posedge clk);
    #1 mon_en = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    chk("reset_state", {busy, done, div_by_zero, result_hi, result_lo}, 67'd0);
    @(negedge clk);

    run_op("mulu_max", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {1'b0, 32'hFFFF_FFFE, 32'h0000_0001});
    run_op("mul_neg",  2'd1, 32'hFFFF_FFFD, 32'd7,         {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB});
    run_op("div_neg",  2'd3, 32'hFFFF_FFF9, 32'd2,         {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_op("divu_zero", 2'd2, 32'h0000_0064, 32'd0,        {1'b1, 32'h0000_0064, 32'hFFFF_FFFF});
    @(negedge clk);
    chk("dbz_held", 65'(div_by_zero), 65'd1);
    run_op("mulu_small", 2'd0, 32'd2, 32'd3,               {1'b0, 32'd0, 32'd6});
    run_op("div_ovf",  2'd3, 32'h8000_0000, 32'hFFFF_FFFF, {1'b0, 32'h0000_0000, 32'h8000_0000});
    run_op("div_zero_neg", 2'd3, 32'hFFFF_FF00, 32'd0,     {1'b1, 32'hFFFF_FF00, 32'hFFFF_FFFF});

    // Starts with other operands while busy must be ignored.
    issue(2'd2, 32'd100, 32'd7);
    lat = 0;
    while (!done && lat < 40) begin
      if (lat >= 4 && lat < 20) begin
        start = 1'($urandom); op = 2'($urandom); op_a = $urandom; op_b = $urandom;
      end else start = 1'b0;
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    chk("noise_latency", 65'(lat), 65'd33);
    chk("noise_result", {div_by_zero, result_hi, result_lo}, {1'b0, 32'd2, 32'd14});
    // Back-to-back issue from the done cycle.
    issue(2'd0, 32'd5, 32'd7);
    wait_done(lat, bcyc);
    chk("b2b_latency", 65'(lat), 65'd33);
    chk("b2b_result", {div_by_zero, result_hi, result_lo}, {1'b0, 32'd0, 32'd35});

    // Reset in the middle of an operation aborts it.
    @(negedge clk);
    issue(2'd1, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (9) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("abort_state", {busy, done, div_by_zero, result_hi, result_lo}, 67'd0);
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort_no_done", 65'(ndone), 65'd0);
    run_op("after_reset", 2'd3, 32'hFFFF_FF9C, 32'd7,      {1'b0, 32'hFFFF_FFFE, 32'hFFFF_FFF2});

    // Randomized traffic: model tracks acceptance, results and rare resets.
    for (int i = 0; i < 6000; i++) begin
      reset = ($urandom % 2500) != 0;
      start = ($urandom % 4) == 0;
      op    = 2'($urandom);
      op_a  = pick();
      op_b  = pick();
      @(negedge clk);
    end
    reset = 1'b1;
    start = 1'b0;
    repeat (40) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
